// File: rtl/pll_clk_monitor.sv
// PLL output qualifier: counts CLK cycles over a window of REF_CLK periods and
// raises CLK_GOOD once LOCK is held and enough consecutive windows are in tolerance.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | no lock; counters held at zero
// S_ALIGN   | locked; waiting for a REF_CLK rising edge to open a window
// S_MEASURE | counting CLK cycles until REF_CYCLES ref edges or saturation
module pll_clk_monitor #(
  parameter int REF_CYCLES     = 16,
  parameter int EXPECTED_COUNT = 160,
  parameter int TOLERANCE      = 2,
  parameter int STABLE_WINDOWS = 4,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   REF_CLK,
  input  logic                   LOCK,
  output logic [COUNT_WIDTH-1:0] MEAS_COUNT,
  output logic                   MEAS_VALID,
  output logic                   CLK_GOOD,
  output logic                   FREQ_ERR
);

  localparam int EDGE_W = $clog2(REF_CYCLES + 1);
  localparam int GOOD_W = $clog2(STABLE_WINDOWS + 1);

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [COUNT_WIDTH-1:0] EXP_C     = COUNT_WIDTH'(EXPECTED_COUNT);
  localparam logic [COUNT_WIDTH:0]   TOL_C     = (COUNT_WIDTH+1)'(TOLERANCE);
  localparam logic [EDGE_W-1:0]      EDGE_LAST = EDGE_W'(REF_CYCLES - 1);
  localparam logic [GOOD_W-1:0]      GOOD_MAX  = GOOD_W'(STABLE_WINDOWS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ALIGN,
    S_MEASURE
  } state_t;

  state_t                  state;
  logic                    lock_m, lock_s;
  logic                    ref_m, ref_s, ref_d;
  logic                    ref_rise;
  logic [COUNT_WIDTH-1:0]  cnt;
  logic [COUNT_WIDTH-1:0]  cnt_inc;
  logic [EDGE_W-1:0]       edges;
  logic [GOOD_W-1:0]       good;
  logic [GOOD_W-1:0]       good_nx;
  logic signed [COUNT_WIDTH:0] diff;
  logic [COUNT_WIDTH:0]    diff_abs;
  logic                    in_tol;
  logic                    sat_end;
  logic                    ref_end;
  logic                    win_end;
  logic                    win_pass;

  logic [COUNT_WIDTH-1:0]  meas_count;
  logic                    meas_valid;
  logic                    clk_good;
  logic                    freq_err;

  // LOCK and REF_CLK are asynchronous to CLK; REF_CLK is treated as data.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
      ref_m  <= 1'b0;
      ref_s  <= 1'b0;
      ref_d  <= 1'b0;
    end else begin
      lock_m <= LOCK;
      lock_s <= lock_m;
      ref_m  <= REF_CLK;
      ref_s  <= ref_m;
      ref_d  <= ref_s;
    end
  end

  assign ref_rise = ref_s & ~ref_d;

  // cnt_inc already includes the current cycle, so it is the window count on an end.
  assign cnt_inc  = (cnt == CNT_MAX) ? CNT_MAX : cnt + COUNT_WIDTH'(1);
  assign sat_end  = (cnt_inc == CNT_MAX);
  assign ref_end  = ref_rise && (edges == EDGE_LAST);
  assign win_end  = (state == S_MEASURE) && (sat_end || ref_end);

  assign diff     = $signed({1'b0, cnt_inc}) - $signed({1'b0, EXP_C});
  assign diff_abs = diff[COUNT_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
  assign in_tol   = (diff_abs <= TOL_C);
  assign win_pass = in_tol && !sat_end;

  assign good_nx  = (good == GOOD_MAX) ? good : good + GOOD_W'(1);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= S_IDLE;
      cnt        <= '0;
      edges      <= '0;
      good       <= '0;
      meas_count <= '0;
      meas_valid <= 1'b0;
      clk_good   <= 1'b0;
      freq_err   <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (!lock_s) begin
        // Lock loss overrides any window ending in the same cycle.
        state    <= S_IDLE;
        cnt      <= '0;
        edges    <= '0;
        good     <= '0;
        clk_good <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            cnt   <= '0;
            edges <= '0;
            state <= S_ALIGN;
          end
          S_ALIGN: begin
            cnt   <= '0;
            edges <= '0;
            if (ref_rise) state <= S_MEASURE;
          end
          S_MEASURE: begin
            cnt <= cnt_inc;
            if (ref_rise) edges <= edges + EDGE_W'(1);
            if (win_end) begin
              meas_count <= cnt_inc;
              meas_valid <= 1'b1;
              cnt        <= '0;
              edges      <= '0;
              if (win_pass) begin
                good <= good_nx;
                if (good_nx == GOOD_MAX) clk_good <= 1'b1;
              end else begin
                good     <= '0;
                clk_good <= 1'b0;
                freq_err <= 1'b1;
              end
              // A ref edge that closes a window also opens the next one.
              if (sat_end) state <= S_ALIGN;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign MEAS_COUNT = meas_count;
  assign MEAS_VALID = meas_valid;
  assign CLK_GOOD   = clk_good;
  assign FREQ_ERR   = freq_err;

endmodule

// File: tb/tb_pll_clk_monitor.sv
// Directed bench for pll_clk_monitor: nominal, tolerance edges, off-frequency,
// lock loss, reset mid-run and REF stall.
module tb_pll_clk_monitor;

  logic clk   = 1'b0;
  logic clk_f = 1'b0;
  logic rst   = 1'b1;
  logic lock  = 1'b0;
  logic ref_clk = 1'b0;
  logic ref_run = 1'b1;

  logic [15:0] m_count, p_count, q_count, f_count;
  logic        m_valid, p_valid, q_valid, f_valid;
  logic        m_good,  p_good,  q_good,  f_good;
  logic        m_err,   p_err,   q_err,   f_err;

  int n_cmp = 0;
  int n_err = 0;

  always #1250 clk = ~clk;
  always #1200 clk_f = ~clk_f;
  always begin
    #12500;
    if (ref_run) ref_clk = ~ref_clk;
    else         ref_clk = 1'b0;
  end

  pll_clk_monitor dut_m (
    .CLK(clk), .RESET(rst), .REF_CLK(ref_clk), .LOCK(lock),
    .MEAS_COUNT(m_count), .MEAS_VALID(m_valid), .CLK_GOOD(m_good), .FREQ_ERR(m_err)
  );

  pll_clk_monitor #(.EXPECTED_COUNT(158)) dut_p158 (
    .CLK(clk), .RESET(rst), .REF_CLK(ref_clk), .LOCK(lock),
    .MEAS_COUNT(p_count), .MEAS_VALID(p_valid), .CLK_GOOD(p_good), .FREQ_ERR(p_err)
  );

  pll_clk_monitor #(.EXPECTED_COUNT(157)) dut_q157 (
    .CLK(clk), .RESET(rst), .REF_CLK(ref_clk), .LOCK(lock),
    .MEAS_COUNT(q_count), .MEAS_VALID(q_valid), .CLK_GOOD(q_good), .FREQ_ERR(q_err)
  );

  pll_clk_monitor dut_fast (
    .CLK(clk_f), .RESET(rst), .REF_CLK(ref_clk), .LOCK(lock),
    .MEAS_COUNT(f_count), .MEAS_VALID(f_valid), .CLK_GOOD(f_good), .FREQ_ERR(f_err)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Returns nominal when v lies in [lo,hi], otherwise v itself so a miss shows the real count.
  function automatic int near(input int v, input int lo, input int hi, input int nominal);
    return (v >= lo && v <= hi) ? nominal : v;
  endfunction

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_valid && n < budget);
    if (!m_valid) chk({tag, "_timeout"}, 0, 1);
  endtask

  // Four windows after (re)lock: CLK_GOOD only with the fourth.
  task automatic four_windows(input string tag, input bit err_exp);
    for (int w = 1; w <= 4; w++) begin
      wait_valid(tag, 400);
      chk({tag, "_cnt"},  near(int'(m_count), 159, 161, 160), 160);
      chk({tag, "_good"}, int'(m_good), (w == 4) ? 1 : 0);
      chk({tag, "_err"},  int'(m_err), int'(err_exp));
    end
    @(negedge clk);
    chk({tag, "_pulse"}, int'(m_valid), 0);
  endtask

  initial begin
    int nv;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_count", int'(m_count), 0);
    chk("rst_valid", int'(m_valid), 0);
    chk("rst_good",  int'(m_good), 0);
    chk("rst_err",   int'(m_err), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Nominal lock-up, with tolerance-boundary instances alongside
    lock = 1'b1;
    for (int w = 1; w <= 4; w++) begin
      wait_valid("nom", 400);
      chk("nom_cnt",  near(int'(m_count), 159, 161, 160), 160);
      chk("nom_good", int'(m_good), (w == 4) ? 1 : 0);
      chk("nom_err",  int'(m_err), 0);
      chk("tol158_err", int'(p_err), 0);
      chk("tol157_err", int'(q_err), 1);
      chk("tol157_good", int'(q_good), 0);
    end
    chk("tol158_good", int'(p_good), 1);
    @(negedge clk);
    chk("nom_pulse", int'(m_valid), 0);

    // Off-frequency instance (CLK 2400 ps)
    chk("fast_cnt",  near(int'(f_count), 166, 167, 166), 166);
    chk("fast_err",  int'(f_err), 1);
    chk("fast_good", int'(f_good), 0);

    // Lock loss
    lock = 1'b0;
    repeat (2) @(negedge clk);
    chk("ll_good_2clk", int'(m_good), 1);
    @(negedge clk);
    chk("ll_good_3clk", int'(m_good), 0);
    nv = 0;
    repeat (100) begin
      @(negedge clk);
      if (m_valid) nv++;
    end
    chk("ll_no_valid", nv, 0);
    chk("ll_err_kept", int'(m_err), 0);
    chk("ll_cnt_kept", near(int'(m_count), 159, 161, 160), 160);
    lock = 1'b1;
    four_windows("relock", 1'b0);

    // Reset during MEASURE with CLK_GOOD high
    repeat (50) @(negedge clk);
    chk("mid_good_pre", int'(m_good), 1);
    rst = 1'b1;
    #1;
    chk("arst_count", int'(m_count), 0);
    chk("arst_good",  int'(m_good), 0);
    chk("arst_err",   int'(m_err), 0);
    chk("arst_valid", int'(m_valid), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    four_windows("postrst", 1'b0);

    // REF stall: window saturates
    ref_run = 1'b0;
    wait_valid("stall", 70000);
    chk("stall_cnt",  int'(m_count), 65535);
    chk("stall_err",  int'(m_err), 1);
    chk("stall_good", int'(m_good), 0);
    ref_run = 1'b1;
    wait_valid("resume", 400);
    chk("resume_cnt",  near(int'(m_count), 159, 161, 160), 160);
    chk("resume_err",  int'(m_err), 1);
    chk("resume_good", int'(m_good), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
